// File: rtl/t05_huffman_decoder.sv
// Huffman bitstream decoder: walks the code tree held in an external node
// memory, one compressed bit per tree level, and emits one character per
// leaf reached until total_chars characters have been produced.
//
// Ports
//   clk, nrst            clock, asynchronous active-low reset
//   en                   clock enable; low freezes all state and outputs
//   start                begin a decode (honoured only when idle)
//   root_idx             tree root index, sampled on start
//   total_chars          number of characters to decode, sampled on start
//   node_addr, node_rd   node memory request, held until node_ack
//   node_ack, node_data  node memory response ([18] leaf flag,
//                        [17:9]/[8:0] left/right child, [7:0] leaf char)
//   bit_in, bit_valid    compressed bit stream
//   bit_ready            decoder takes a bit this cycle
//   char_out, char_valid decoded character stream
//   char_ready           sink takes the character this cycle
//   busy                 high whenever not idle
//   done                 one-cycle completion pulse
//   error                sticky malformed-tree / over-depth flag
module t05_huffman_decoder #(
   parameter int unsigned NODE_AW   = 9,
   parameter int unsigned CHAR_W    = 8,
   parameter int unsigned MAX_DEPTH = 255
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               en,
   input  logic               start,
   input  logic [NODE_AW-1:0] root_idx,
   input  logic [31:0]        total_chars,
   output logic [NODE_AW-1:0] node_addr,
   output logic               node_rd,
   input  logic               node_ack,
   input  logic [18:0]        node_data,
   input  logic               bit_in,
   input  logic               bit_valid,
   output logic               bit_ready,
   output logic [CHAR_W-1:0]  char_out,
   output logic               char_valid,
   input  logic               char_ready,
   output logic               busy,
   output logic               done,
   output logic               error
);

   localparam int unsigned DEPTH_W = $clog2(MAX_DEPTH + 2);
   localparam int unsigned NODE_W  = 19;
   localparam int unsigned CNT_W   = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_WAIT_BIT,
      S_EMIT,
      S_DONE,
      S_ERR
   } state_t;

   state_t             state;
   logic [NODE_AW-1:0] root;
   logic [NODE_AW-1:0] cur;
   logic [CNT_W-1:0]   total;
   logic [CNT_W-1:0]   cnt;
   logic [DEPTH_W-1:0] depth;
   logic [NODE_W-1:0]  node_q;
   logic               root_leaf;

   logic               node_leaf_c;
   logic [NODE_AW-1:0] node_left_c;
   logic [NODE_AW-1:0] node_right_c;
   logic [NODE_AW-1:0] child_c;
   logic [CHAR_W-1:0]  node_char_c;
   logic [DEPTH_W-1:0] depth_inc_c;
   logic [CNT_W-1:0]   cnt_inc_c;

   // Field split of the latched node word and the incremented counters.
   always_comb begin
      node_leaf_c  = node_q[18];
      node_left_c  = NODE_AW'(node_q[17:9]);
      node_right_c = NODE_AW'(node_q[8:0]);
      node_char_c  = CHAR_W'(node_q[7:0]);
      child_c      = bit_in ? node_right_c : node_left_c;
      depth_inc_c  = depth + DEPTH_W'(1);
      cnt_inc_c    = cnt + CNT_W'(1);
   end

   // Decoder FSM; every output is registered and set on entry to the state
   // that owns it, except done/error which are raised by their own state.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state      <= S_IDLE;
         root       <= '0;
         cur        <= '0;
         total      <= '0;
         cnt        <= '0;
         depth      <= '0;
         node_q     <= '0;
         root_leaf  <= 1'b0;
         node_addr  <= '0;
         node_rd    <= 1'b0;
         bit_ready  <= 1'b0;
         char_out   <= '0;
         char_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else if (en) begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  root  <= root_idx;
                  total <= total_chars;
                  cnt   <= '0;
                  error <= 1'b0;
                  busy  <= 1'b1;
                  if (total_chars == '0) begin
                     state <= S_DONE;
                  end else begin
                     cur       <= root_idx;
                     depth     <= '0;
                     node_addr <= root_idx;
                     node_rd   <= 1'b1;
                     state     <= S_FETCH;
                  end
               end
            end

            S_FETCH: begin
               if (node_ack) begin
                  node_q  <= node_data;
                  node_rd <= 1'b0;
                  state   <= S_DECODE;
               end
            end

            S_DECODE: begin
               if (node_leaf_c) begin
                  // A leaf at depth 0 is a one-symbol tree: one dummy bit
                  // per character is still sent by the encoder.
                  if (depth == '0) begin
                     root_leaf <= 1'b1;
                     bit_ready <= 1'b1;
                     state     <= S_WAIT_BIT;
                  end else begin
                     root_leaf  <= 1'b0;
                     char_out   <= node_char_c;
                     char_valid <= 1'b1;
                     state      <= S_EMIT;
                  end
               end else if ((node_left_c == cur) || (node_right_c == cur)) begin
                  // Self-referencing node would loop forever.
                  state <= S_ERR;
               end else begin
                  root_leaf <= 1'b0;
                  bit_ready <= 1'b1;
                  state     <= S_WAIT_BIT;
               end
            end

            S_WAIT_BIT: begin
               if (bit_valid) begin
                  bit_ready <= 1'b0;
                  depth     <= depth_inc_c;
                  if (depth_inc_c > DEPTH_W'(MAX_DEPTH)) begin
                     state <= S_ERR;
                  end else if (root_leaf) begin
                     char_out   <= node_char_c;
                     char_valid <= 1'b1;
                     state      <= S_EMIT;
                  end else begin
                     cur       <= child_c;
                     node_addr <= child_c;
                     node_rd   <= 1'b1;
                     state     <= S_FETCH;
                  end
               end
            end

            S_EMIT: begin
               if (char_ready) begin
                  char_valid <= 1'b0;
                  cnt        <= cnt_inc_c;
                  if (cnt_inc_c == total) begin
                     state <= S_DONE;
                  end else begin
                     cur       <= root;
                     depth     <= '0;
                     node_addr <= root;
                     node_rd   <= 1'b1;
                     state     <= S_FETCH;
                  end
               end
            end

            S_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            S_ERR: begin
               error <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_t05_huffman_decoder.sv
// Self-checking bench for t05_huffman_decoder: directed trees plus random
// trees encoded by a small reference encoder, with a random-latency node
// memory, random bit/character handshakes and random enable gaps.
module tb_t05_huffman_decoder;

   logic        clk;
   logic        nrst;
   logic        en;
   logic        start;
   logic [8:0]  root_idx;
   logic [31:0] total_chars;
   logic [8:0]  node_addr;
   logic        node_rd;
   logic        node_ack;
   logic [18:0] node_data;
   logic        bit_in;
   logic        bit_valid;
   logic        bit_ready;
   logic [7:0]  char_out;
   logic        char_valid;
   logic        char_ready;
   logic        busy;
   logic        done;
   logic        error;

   t05_huffman_decoder dut (
      .clk(clk), .nrst(nrst), .en(en), .start(start),
      .root_idx(root_idx), .total_chars(total_chars),
      .node_addr(node_addr), .node_rd(node_rd), .node_ack(node_ack),
      .node_data(node_data), .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_ready(bit_ready), .char_out(char_out), .char_valid(char_valid),
      .char_ready(char_ready), .busy(busy), .done(done), .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total_n;
   int bad_n;

   logic [18:0] mem [0:511];
   bit          bit_q [$];
   logic [7:0]  got [$];
   logic [7:0]  exp_q [$];
   int          bits_used;
   int          done_cnt;

   // random-tree bookkeeping for the reference encoder
   logic [8:0]  parent [0:511];
   bit          side   [0:511];
   logic [8:0]  leaf_node [0:7];
   logic [7:0]  leaf_chr  [0:7];
   logic [8:0]  tree_root;

   function automatic logic [18:0] mk_leaf(input logic [7:0] c);
      return {1'b1, 10'd0, c};
   endfunction

   function automatic logic [18:0] mk_int(input logic [8:0] l, input logic [8:0] r);
      return {1'b0, l, r};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 512; i++) mem[i] = 19'd0;
   endtask

   task automatic load_abc();
      clear_mem();
      mem[0] = mk_int(9'd1, 9'd2);
      mem[1] = mk_leaf(8'h41);
      mem[2] = mk_int(9'd3, 9'd4);
      mem[3] = mk_leaf(8'h42);
      mem[4] = mk_leaf(8'h43);
   endtask

   // pushes the n-bit pattern v, leftmost bit first
   task automatic load_bits(input int n, input logic [15:0] v);
      bit_q.delete();
      for (int i = n - 1; i >= 0; i--) bit_q.push_back(v[i]);
   endtask

   task automatic do_start(input logic [8:0] r, input logic [31:0] t);
      @(negedge clk);
      en          = 1'b1;
      start       = 1'b1;
      root_idx    = r;
      total_chars = t;
      node_ack    = 1'b0;
      bit_valid   = 1'b0;
      char_ready  = 1'b0;
      @(posedge clk);
   endtask

   // Cycle-based environment: node memory, bit source and character sink.
   // Returns once the decoder is idle again, on abort, or on budget expiry.
   task automatic run(input int budget, input bit rnd, input int stall,
                      input int abort_chars, output bit aborted, output bit timeout);
      bit         pend;
      int         ack_wait;
      logic [8:0] pend_addr;
      bit         holding;
      logic [7:0] hold_char;
      int         stall_left;
      logic       prev_done;
      pend       = 0;
      ack_wait   = 0;
      pend_addr  = '0;
      holding    = 0;
      hold_char  = '0;
      stall_left = 0;
      prev_done  = 1'b0;
      aborted    = 0;
      timeout    = 1;
      got.delete();
      bits_used  = 0;
      done_cnt   = 0;
      for (int cyc = 0; cyc < budget; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         en    = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
         // garbage start while busy must be ignored
         if (rnd && busy && $urandom_range(0, 9) == 0) begin
            start       = 1'b1;
            root_idx    = 9'($urandom);
            total_chars = $urandom;
         end

         node_ack  = 1'b0;
         node_data = 19'($urandom);
         if (node_rd) begin
            if (!pend) begin
               pend      = 1;
               pend_addr = node_addr;
               ack_wait  = rnd ? int'($urandom_range(0, 4)) : 0;
            end else begin
               total_n++;
               if (node_addr !== pend_addr) begin
                  bad_n++;
                  $display("FAIL addr_stable got=%h exp=%h", node_addr, pend_addr);
               end
            end
            if (ack_wait == 0) begin
               node_ack  = 1'b1;
               node_data = mem[node_addr];
               if (en) pend = 0;
            end else if (en) begin
               ack_wait--;
            end
         end

         bit_valid = 1'b0;
         bit_in    = 1'($urandom);
         if (bit_q.size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
            bit_valid = 1'b1;
            bit_in    = bit_q[0];
         end
         if (bit_valid && bit_ready && en) begin
            void'(bit_q.pop_front());
            bits_used++;
         end

         char_ready = rnd ? 1'($urandom) : 1'b0;
         if (char_valid) begin
            total_n++;
            if (bit_ready !== 1'b0) begin
               bad_n++;
               $display("FAIL ready_while_emit got=%b exp=0", bit_ready);
            end
            if (!holding) begin
               holding    = 1;
               hold_char  = char_out;
               stall_left = stall;
            end else begin
               total_n++;
               if (char_out !== hold_char) begin
                  bad_n++;
                  $display("FAIL char_stable got=%h exp=%h", char_out, hold_char);
               end
            end
            if (stall_left > 0) begin
               char_ready = 1'b0;
               if (en) stall_left--;
            end else if (!rnd) begin
               char_ready = 1'b1;
            end
            if (char_ready && en) begin
               got.push_back(char_out);
               holding = 0;
            end
         end

         if (done && !prev_done) done_cnt++;
         prev_done = done;

         if (abort_chars > 0 && got.size() == abort_chars && node_rd) begin
            aborted = 1;
            timeout = 0;
            return;
         end
         if (!busy) begin
            timeout = 0;
            break;
         end
      end
      en = 1'b1;
   endtask

   // Builds a random full binary tree with k leaves by merging random pairs.
   task automatic build_tree(input int k);
      logic [8:0] pool [$];
      logic [8:0] a;
      logic [8:0] b;
      logic [8:0] nxt;
      int         base;
      int         j;
      clear_mem();
      base = int'($urandom_range(1, 200));
      for (int i = 0; i < k; i++) begin
         leaf_node[i] = 9'(base + i);
         leaf_chr[i]  = 8'($urandom);
         mem[leaf_node[i]] = mk_leaf(leaf_chr[i]);
         pool.push_back(leaf_node[i]);
      end
      nxt = 9'(base + k);
      while (pool.size() > 1) begin
         j = int'($urandom_range(0, pool.size() - 1));
         a = pool[j];
         pool.delete(j);
         j = int'($urandom_range(0, pool.size() - 1));
         b = pool[j];
         pool.delete(j);
         mem[nxt]  = mk_int(a, b);
         parent[a] = nxt;
         side[a]   = 1'b0;
         parent[b] = nxt;
         side[b]   = 1'b1;
         pool.push_back(nxt);
         nxt = nxt + 9'd1;
      end
      tree_root = pool[0];
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      en = 1'b1; start = 1'b0; root_idx = '0; total_chars = '0;
      node_ack = 1'b0; node_data = '0; bit_in = 1'b0; bit_valid = 1'b1;
      char_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total_n++;
      if ({node_addr, node_rd, bit_ready, char_out, char_valid, busy, done, error} !== 23'd0) begin
         bad_n++;
         $display("FAIL reset_outputs got=%h exp=0",
                  {node_addr, node_rd, bit_ready, char_out, char_valid, busy, done, error});
      end
      @(negedge clk);
      nrst = 1'b1;
      repeat (2) @(negedge clk);
      total_n++;
      if ({node_rd, bit_ready, busy} !== 3'b000) begin
         bad_n++;
         $display("FAIL idle_after_reset got=%b exp=000", {node_rd, bit_ready, busy});
      end
      bit_valid = 1'b0;
   endtask

   task automatic test_basic();
      bit ab, to;
      load_abc();
      load_bits(6, 16'b010111);
      exp_q = '{8'h41, 8'h42, 8'h43};
      do_start(9'd0, 32'd3);
      run(400, 0, 0, 0, ab, to);
      total_n++;
      if (to) begin bad_n++; $display("FAIL basic_timeout got=1 exp=0"); end
      total_n++;
      if (got.size() != 3) begin bad_n++; $display("FAIL basic_count got=%0d exp=3", got.size()); end
      foreach (exp_q[i]) begin
         total_n++;
         if (i >= got.size() || got[i] !== exp_q[i]) begin
            bad_n++;
            $display("FAIL basic_char%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
         end
      end
      total_n++;
      if (bits_used != 5) begin bad_n++; $display("FAIL basic_bits got=%0d exp=5", bits_used); end
      total_n++;
      if (done_cnt != 1) begin bad_n++; $display("FAIL basic_done got=%0d exp=1", done_cnt); end
      total_n++;
      if (error !== 1'b0) begin bad_n++; $display("FAIL basic_error got=%b exp=0", error); end
   endtask

   task automatic test_stall();
      bit ab, to;
      load_abc();
      load_bits(7, 16'b1110001);
      exp_q = '{8'h43, 8'h42, 8'h41, 8'h41};
      do_start(9'd0, 32'd4);
      run(600, 0, 5, 0, ab, to);
      total_n++;
      if (to) begin bad_n++; $display("FAIL stall_timeout got=1 exp=0"); end
      total_n++;
      if (got.size() != 4) begin bad_n++; $display("FAIL stall_count got=%0d exp=4", got.size()); end
      foreach (exp_q[i]) begin
         total_n++;
         if (i >= got.size() || got[i] !== exp_q[i]) begin
            bad_n++;
            $display("FAIL stall_char%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
         end
      end
      total_n++;
      if (bits_used != 6) begin bad_n++; $display("FAIL stall_bits got=%0d exp=6", bits_used); end
      total_n++;
      if (done_cnt != 1) begin bad_n++; $display("FAIL stall_done got=%0d exp=1", done_cnt); end
   endtask

   task automatic test_single_leaf();
      bit ab, to;
      clear_mem();
      mem[0] = mk_leaf(8'h7A);
      load_bits(5, 16'b10111);
      do_start(9'd0, 32'd3);
      run(400, 0, 0, 0, ab, to);
      total_n++;
      if (to) begin bad_n++; $display("FAIL leaf_timeout got=1 exp=0"); end
      total_n++;
      if (got.size() != 3) begin bad_n++; $display("FAIL leaf_count got=%0d exp=3", got.size()); end
      foreach (got[i]) begin
         total_n++;
         if (got[i] !== 8'h7A) begin bad_n++; $display("FAIL leaf_char%0d got=%h exp=7a", i, got[i]); end
      end
      total_n++;
      if (bits_used != 3) begin bad_n++; $display("FAIL leaf_bits got=%0d exp=3", bits_used); end
      total_n++;
      if (done_cnt != 1) begin bad_n++; $display("FAIL leaf_done got=%0d exp=1", done_cnt); end
   endtask

   task automatic test_zero_total();
      load_abc();
      do_start(9'd0, 32'd0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         start = 1'b0;
         total_n++;
         if (done !== (k == 2)) begin
            bad_n++;
            $display("FAIL zero_done_c%0d got=%b exp=%b", k, done, (k == 2));
         end
         total_n++;
         if ({node_rd, bit_ready, char_valid} !== 3'b000) begin
            bad_n++;
            $display("FAIL zero_quiet_c%0d got=%b exp=000", k, {node_rd, bit_ready, char_valid});
         end
      end
   endtask

   task automatic test_error();
      bit ab, to;
      clear_mem();
      mem[0] = mk_int(9'd0, 9'd5);
      mem[5] = mk_leaf(8'h55);
      load_bits(3, 16'b101);
      do_start(9'd0, 32'd2);
      run(400, 0, 0, 0, ab, to);
      total_n++;
      if (to) begin bad_n++; $display("FAIL err_timeout got=1 exp=0"); end
      total_n++;
      if (error !== 1'b1) begin bad_n++; $display("FAIL err_flag got=%b exp=1", error); end
      total_n++;
      if (got.size() != 0) begin bad_n++; $display("FAIL err_chars got=%0d exp=0", got.size()); end
      total_n++;
      if (done_cnt != 0) begin bad_n++; $display("FAIL err_done got=%0d exp=0", done_cnt); end
      repeat (2) @(negedge clk);
      total_n++;
      if ({error, busy} !== 2'b10) begin bad_n++; $display("FAIL err_sticky got=%b exp=10", {error, busy}); end
      load_abc();
      load_bits(6, 16'b010111);
      do_start(9'd0, 32'd3);
      #1;
      total_n++;
      if (error !== 1'b0) begin bad_n++; $display("FAIL err_clear got=%b exp=0", error); end
      run(400, 0, 0, 0, ab, to);
      total_n++;
      if (got.size() != 3 || error !== 1'b0) begin
         bad_n++;
         $display("FAIL err_recover got=%0d/%b exp=3/0", got.size(), error);
      end
   endtask

   task automatic test_reset_mid();
      bit ab, to;
      load_abc();
      load_bits(6, 16'b010111);
      do_start(9'd0, 32'd3);
      run(600, 1, 0, 1, ab, to);
      total_n++;
      if (!ab) begin bad_n++; $display("FAIL mid_reached got=0 exp=1"); end
      #2 nrst = 1'b0;
      #1;
      total_n++;
      if ({node_addr, node_rd, bit_ready, char_out, char_valid, busy, done, error} !== 23'd0) begin
         bad_n++;
         $display("FAIL mid_reset got=%h exp=0",
                  {node_addr, node_rd, bit_ready, char_out, char_valid, busy, done, error});
      end
      total_n++;
      if (got.size() != 1 || got[0] !== 8'h41) begin
         bad_n++;
         $display("FAIL mid_first got=%0d exp=1", got.size());
      end
      @(negedge clk);
      nrst = 1'b1;
      en   = 1'b1;
      load_bits(6, 16'b010111);
      exp_q = '{8'h41, 8'h42, 8'h43};
      do_start(9'd0, 32'd3);
      run(2000, 1, 0, 0, ab, to);
      total_n++;
      if (to) begin bad_n++; $display("FAIL mid_timeout got=1 exp=0"); end
      total_n++;
      if (got.size() != 3) begin bad_n++; $display("FAIL mid_count got=%0d exp=3", got.size()); end
      foreach (exp_q[i]) begin
         total_n++;
         if (i >= got.size() || got[i] !== exp_q[i]) begin
            bad_n++;
            $display("FAIL mid_char%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
         end
      end
      total_n++;
      if (bits_used != 5) begin bad_n++; $display("FAIL mid_bits got=%0d exp=5", bits_used); end
   endtask

   task automatic test_random();
      bit         ab, to;
      int         k, n, li, exp_bits;
      logic [8:0] nd;
      bit         code [$];
      for (int it = 0; it < 8; it++) begin
         k = int'($urandom_range(1, 8));
         build_tree(k);
         n = int'($urandom_range(1, 10));
         exp_q.delete();
         bit_q.delete();
         exp_bits = 0;
         for (int c = 0; c < n; c++) begin
            li = int'($urandom_range(0, k - 1));
            exp_q.push_back(leaf_chr[li]);
            code.delete();
            if (k == 1) begin
               code.push_back(1'($urandom));
            end else begin
               nd = leaf_node[li];
               while (nd != tree_root) begin
                  code.push_front(side[nd]);
                  nd = parent[nd];
               end
            end
            foreach (code[b]) bit_q.push_back(code[b]);
            exp_bits += code.size();
         end
         bit_q.push_back(1'($urandom));
         bit_q.push_back(1'($urandom));
         do_start(tree_root, 32'(n));
         run(5000, 1, 0, 0, ab, to);
         total_n++;
         if (to) begin bad_n++; $display("FAIL rnd%0d_timeout got=1 exp=0", it); end
         total_n++;
         if (got.size() != n) begin bad_n++; $display("FAIL rnd%0d_count got=%0d exp=%0d", it, got.size(), n); end
         foreach (exp_q[i]) begin
            total_n++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
               bad_n++;
               $display("FAIL rnd%0d_char%0d got=%h exp=%h", it, i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
         end
         total_n++;
         if (bits_used != exp_bits) begin
            bad_n++;
            $display("FAIL rnd%0d_bits got=%0d exp=%0d", it, bits_used, exp_bits);
         end
         total_n++;
         if (done_cnt != 1 || error !== 1'b0) begin
            bad_n++;
            $display("FAIL rnd%0d_end got=%0d/%b exp=1/0", it, done_cnt, error);
         end
      end
   endtask

   initial begin
      total_n = 0;
      bad_n   = 0;
      test_reset();
      test_basic();
      test_stall();
      test_single_leaf();
      test_zero_total();
      test_error();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule
